bitmap_mem_ctrl: RTL and testbench
==================================

# bitmap_mem_ctrl

Memory-side responder for the CPU's bitmap load/store instructions (ldb/stb). Accepts one 1536-bit bitmap request per handshake from the execute stage and sequences it as 96 single-word accesses on the 16-bit bitmap memory port. Returns assembled read data for loads and a completion pulse for stores. Sits between the execute/writeback pipeline and the bitmap memory instance, hiding the memory's word width and read latency from the pipeline.

## Interface
- BMP_W, 1536, bitmap width in bits
- WORD_W, 16, memory word width; beats = BMP_W/WORD_W = 96
- ADDR_W, 16, memory word-address width

- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_we  input  1  1 = store (stb), 0 = load (ldb)
- req_addr  input  ADDR_W  base word address
- req_wdata  input  BMP_W  store data
- rsp_valid  output  1  one-cycle completion pulse
- rsp_err  output  1  request rejected (only with BMP_WRAP_GUARD_EN)
- rsp_rdata  output  BMP_W  load data, held until next load completes
- mem_addr  output  ADDR_W  memory word address
- mem_wren  output  1  memory write enable
- mem_wdata  output  WORD_W  memory write data
- mem_q  input  WORD_W  memory read data, valid one cycle after mem_addr

## Operation
- States: IDLE, WRITE, READ, DRAIN, RESP.
- req_ready = 1 only in IDLE. Accept on req_valid && req_ready; latch req_we, req_addr, req_wdata; clear 7-bit beat counter.
- Word ordering: beat i uses address base+i and bits [16i+15:16i]; bits [15:0] at base.
- WRITE: each cycle drive mem_addr = base+i, mem_wren = 1, mem_wdata = beat i. After beat 95 go to RESP.
- READ: each cycle drive mem_addr = base+i, mem_wren = 0. Capture mem_q into beat i-1 of rsp_rdata. After issuing beat 95 go to DRAIN, which captures beat 95, then RESP.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE. No back-pressure; the consumer must take the pulse.
- Stores leave rsp_rdata unchanged.
- Address arithmetic is modulo 2^ADDR_W: base+i wraps 0xFFFF -> 0x0000.
- mem_wren is 0 in every state except WRITE.
- req_valid while busy is ignored; the requester holds it until req_ready.

## Timing
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_err 0, rsp_rdata 0, mem_addr 0, mem_wren 0, mem_wdata 0.
- Accept edge = cycle 0.
  - Store: writes in cycles 1–96; rsp_valid in cycle 97; req_ready in cycle 98.
  - Load: addresses in cycles 1–96; DRAIN in cycle 97; rsp_valid in cycle 98 with full rsp_rdata; req_ready in cycle 99.
- Back-to-back requests: next accept no earlier than the first IDLE cycle.
- Reset mid-operation: immediate return to IDLE and mem_wren = 0. Already-written words stay in memory. No rsp_valid is produced for the aborted request.

## Configuration
- BMP_WRAP_GUARD_EN defined:
  - A request with req_addr + 95 > 0xFFFF is accepted, then goes straight to RESP with no memory access.
  - rsp_valid and rsp_err assert together in cycle 1.
  - rsp_rdata is unchanged.
- BMP_WRAP_GUARD_EN undefined: addresses wrap modulo 2^16, and rsp_err is tied 0.

## Structure
- Package bmp_pkg holds:
  - BMP_W, WORD_W, ADDR_W
  - BEATS = 96 and BEAT_CNT_W = 7
  - the state enum
- No sub-module. FSM, beat counter and data registers live in one module.
- rsp_rdata captures per beat via an indexed part-select (not a shift register), so partial data stays beat-aligned.

## Test plan
- Store base 0x0100, beat i data = 0xA000+i -> 96 writes at 0x0100–0x015F with matching data, mem_wren high exactly 96 cycles, rsp_valid cycle 97.
- Load base 0x0100 from memory model holding 0xA000+i -> rsp_valid cycle 98, rsp_rdata[15:0] = 0xA000, rsp_rdata[1535:1520] = 0xA05F.
- Load base 0xFFF0, guard disabled -> addresses 0xFFF0–0xFFFF then 0x0000–0x004F, data assembled in that order. Guard enabled -> rsp_valid and rsp_err in cycle 1, no mem access.
- req_valid held high through a store followed by a load -> second accept only in the first IDLE cycle; req_ready never high while busy.
- rst_n low at cycle 40 of a store -> mem_wren 0 immediately, no rsp_valid, req_ready 1. The next load returns correct data.
- Store then load same base with random data -> rsp_rdata equals stored bitmap bit-for-bit.

Source files
------------

// File: rtl/bitmap_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bmp_pkg
// Description : Shared constants and FSM state type for the bitmap memory
//               controller (ldb/stb responder).
// Revision    : 1.0 - initial release
// ============================================================================
package bmp_pkg;

  localparam int unsigned BMP_W      = 1536;            // bitmap width in bits
  localparam int unsigned WORD_W     = 16;              // memory word width
  localparam int unsigned ADDR_W     = 16;              // memory word address width
  localparam int unsigned BEATS      = BMP_W / WORD_W;  // 96 word accesses per bitmap
  localparam int unsigned BEAT_CNT_W = 7;               // holds 0..96
  localparam int unsigned BIT_OFF_W  = $clog2(BMP_W);   // bit offset of a beat in the bitmap

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bitmap_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : bitmap_mem_ctrl_if
// Description : Request/response bundle between the execute stage (master)
//               and the bitmap memory controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface bitmap_mem_ctrl_if;
  import bmp_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [BMP_W-1:0]  req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [BMP_W-1:0]  rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );

endinterface
`default_nettype wire

// File: rtl/bitmap_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bitmap_mem_ctrl
// Description : Sequences one 1536-bit bitmap load/store as 96 single-word
//               accesses on a 16-bit memory port with one-cycle read latency.
//               Optional macro BMP_WRAP_GUARD_EN: reject requests whose word
//               range would wrap past 0xFFFF (rsp_err with no memory access).
// Revision    : 1.0 - initial release
// ============================================================================
module bitmap_mem_ctrl
  import bmp_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              rst_n,
  bitmap_mem_ctrl_if.slave       bus,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic                   mem_wren_o,
  output logic [WORD_W-1:0]      mem_wdata_o,
  input  wire logic [WORD_W-1:0] mem_q_i
);

  state_t                state_q, state_d;
  logic [BEAT_CNT_W-1:0] cnt_q;
  logic [ADDR_W-1:0]     base_q;
  logic [BMP_W-1:0]      wdata_q;
  logic [BMP_W-1:0]      rdata_q;

  logic                  w_accept;
  logic                  w_last_beat;
  logic                  w_guard_hit;
  logic                  w_capture;
  logic [ADDR_W-1:0]     w_beat_addr;
  logic [BEAT_CNT_W-1:0] w_cap_beat;
  logic [BIT_OFF_W-1:0]  w_wr_off;
  logic [BIT_OFF_W-1:0]  w_cap_off;

  assign w_accept    = (state_q == ST_IDLE) && bus.req_valid;
  assign w_last_beat = (cnt_q == BEAT_CNT_W'(BEATS - 1));
  // Address arithmetic deliberately truncates to ADDR_W so base+i wraps.
  assign w_beat_addr = base_q + ADDR_W'(cnt_q);
  assign w_wr_off    = BIT_OFF_W'(cnt_q) << $clog2(WORD_W);
  // Read data for beat i arrives one cycle after its address, so the capture
  // slot trails the counter by one; DRAIN sees cnt_q == 96 and stores beat 95.
  assign w_cap_beat  = cnt_q - 1'b1;
  assign w_cap_off   = BIT_OFF_W'(w_cap_beat) << $clog2(WORD_W);
  assign w_capture   = ((state_q == ST_READ) && (cnt_q != '0)) || (state_q == ST_DRAIN);

`ifdef BMP_WRAP_GUARD_EN
  logic [ADDR_W:0] w_last_addr;
  logic            err_q;

  // One extra bit exposes a carry out of the last beat's address.
  assign w_last_addr = {1'b0, bus.req_addr} + (ADDR_W + 1)'(BEATS - 1);
  assign w_guard_hit = w_last_addr[ADDR_W];
  assign bus.rsp_err = err_q && (state_q == ST_RESP);

  // Remember whether the accepted request was rejected by the wrap guard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (w_accept) begin
      err_q <= w_guard_hit;
    end
  end
`else
  assign w_guard_hit = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.rsp_rdata = rdata_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and per-state outputs.
  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    mem_addr_o    = '0;
    mem_wren_o    = 1'b0;
    mem_wdata_o   = '0;
    unique case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (w_guard_hit) begin
            state_d = ST_RESP;
          end else if (bus.req_we) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        mem_addr_o  = w_beat_addr;
        mem_wren_o  = 1'b1;
        mem_wdata_o = wdata_q[w_wr_off +: WORD_W];
        if (w_last_beat) begin
          state_d = ST_RESP;
        end
      end
      ST_READ: begin
        mem_addr_o = w_beat_addr;
        if (w_last_beat) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request latch, beat counter and beat-aligned read-data assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (w_accept) begin
        cnt_q   <= '0;
        base_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end else if ((state_q == ST_WRITE) || (state_q == ST_READ)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (w_capture) begin
        rdata_q[w_cap_off +: WORD_W] <= mem_q_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bitmap_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitmap_mem_ctrl
// Description : Self-checking bench for bitmap_mem_ctrl: reset values, a
//               vector table of loads/stores, back-to-back, random
//               store/load pairs and a reset in the middle of a store.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitmap_mem_ctrl;
  import bmp_pkg::*;

`ifdef BMP_WRAP_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bitmap_mem_ctrl_if bus();

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wren;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_q;

  bitmap_mem_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .mem_addr_o  (mem_addr),
    .mem_wren_o  (mem_wren),
    .mem_wdata_o (mem_wdata),
    .mem_q_i     (mem_q)
  );

  // Memory contents before any store: a fixed function of the address.
  function automatic logic [15:0] init_word(input int a);
    return 16'(a) ^ 16'h5A5A;
  endfunction

  // Behavioural synchronous-read memory driven by the DUT port.
  logic [15:0] mem [int];
  always @(posedge clk) begin
    mem_q <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : init_word(int'(mem_addr));
    if (mem_wren) mem[int'(mem_addr)] = mem_wdata;
  end

  // Reference model: word array updated from requests, never from the DUT.
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [BMP_W-1:0] ref_load(input logic [15:0] base);
    logic [BMP_W-1:0] r;
    for (int i = 0; i < int'(BEATS); i++) r[16*i +: 16] = ref_rd((int'(base) + i) % 65536);
    return r;
  endfunction

  task automatic ref_store(input logic [15:0] base, input logic [BMP_W-1:0] d, input int nbeats);
    for (int i = 0; i < nbeats; i++) ref_mem[(int'(base) + i) % 65536] = d[16*i +: 16];
  endtask

  function automatic bit guard_hit(input logic [15:0] base);
    return GUARD && ((int'(base) + int'(BEATS) - 1) > 65535);
  endfunction

  function automatic logic [BMP_W-1:0] rand_bmp();
    logic [BMP_W-1:0] r;
    for (int i = 0; i < int'(BMP_W / 32); i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [BMP_W-1:0] pat_bmp();
    logic [BMP_W-1:0] r;
    for (int i = 0; i < int'(BEATS); i++) r[16*i +: 16] = 16'hA000 + 16'(i);
    return r;
  endfunction

  int n_checks = 0;
  int n_fail   = 0;
  logic [BMP_W-1:0] exp_rdata = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_bmp(input string name, input logic [BMP_W-1:0] got, input logic [BMP_W-1:0] exp);
    int bad;
    bad = 0;
    n_checks++;
    if (got !== exp) begin
      for (int i = int'(BEATS) - 1; i >= 0; i--) if (got[16*i +: 16] !== exp[16*i +: 16]) bad = i;
      n_fail++;
      $display("FAIL %s: beat %0d got %h expected %h", name, bad, got[16*bad +: 16], exp[16*bad +: 16]);
    end
  endtask

  // One complete request: waits for ready, monitors the memory port cycle by
  // cycle and checks latency, error flag, write count, address/data order and
  // the returned bitmap. Entered and left #1 after a rising edge.
  task automatic run_req(input bit we, input logic [15:0] base, input logic [BMP_W-1:0] data,
                         input int exp_lat, input bit exp_err, input string tag);
    int t, lat, n_wr, bus_bad, rdy_busy;
    bit err_seen, active;
    logic [BMP_W-1:0] exp_load;
    t = 0; lat = 0; n_wr = 0; bus_bad = 0; rdy_busy = 0; err_seen = 0;
    exp_load = ref_load(base);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = base; bus.req_wdata = data;
    @(negedge clk);
    while (!bus.req_ready && t < 200) begin @(negedge clk); t++; end
    chk({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    if (!bus.req_ready) begin bus.req_valid = 1'b0; return; end
    @(posedge clk); #1; bus.req_valid = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      active = !exp_err && (k <= int'(BEATS));
      if (mem_wren) n_wr++;
      if (active) begin
        if (mem_addr !== 16'(int'(base) + k - 1)) bus_bad++;
        if (mem_wren !== we) bus_bad++;
        if (we && (mem_wdata !== data[16*(k-1) +: 16])) bus_bad++;
      end else if (mem_wren) begin
        bus_bad++;
      end
      if (bus.rsp_valid) begin lat = k; err_seen = bus.rsp_err; break; end
      if (bus.req_ready) rdy_busy++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " rsp_err"}, 32'(err_seen), 32'(exp_err));
    chk({tag, " write count"}, 32'(n_wr), (we && !exp_err) ? 32'd96 : 32'd0);
    chk({tag, " bus order"}, 32'(bus_bad), 32'd0);
    chk({tag, " ready while busy"}, 32'(rdy_busy), 32'd0);
    if (!we && !exp_err) exp_rdata = exp_load;
    chk_bmp({tag, " rdata"}, bus.rsp_rdata, exp_rdata);
    @(negedge clk);
    chk({tag, " idle after resp"}, {30'd0, bus.req_ready, bus.rsp_valid}, 32'd2);
    if (we && !exp_err) ref_store(base, data, int'(BEATS));
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          we;
    logic [15:0] base;
    int          lat;
    bit          err;
  } vec_t;

  vec_t vt [7];

  initial begin
    logic [BMP_W-1:0] d;
    logic [15:0] base;
    bit g;
    int first_rdy, rsp1, rsp2, rdy_cnt, n_rsp, n_wr;

    // {we, base, expected latency, expected rsp_err}
    vt[0] = '{1'b0, 16'hFFF0, GUARD ? 1 : 98, GUARD};
    vt[1] = '{1'b1, 16'hFFA0, 97, 1'b0};
    vt[2] = '{1'b0, 16'hFFA0, 98, 1'b0};
    vt[3] = '{1'b1, 16'hFFA1, GUARD ? 1 : 97, GUARD};
    vt[4] = '{1'b0, 16'h0000, 98, 1'b0};
    vt[5] = '{1'b1, 16'h1234, 97, 1'b0};
    vt[6] = '{1'b0, 16'h1234, 98, 1'b0};

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    chk_bmp("reset rsp_rdata", bus.rsp_rdata, '0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_wren", 32'(mem_wren), 32'd0);
    chk("reset mem_wdata", 32'(mem_wdata), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Known pattern store and load at 0x0100.
    run_req(1'b1, 16'h0100, pat_bmp(), 97, 1'b0, "store 0100");
    run_req(1'b0, 16'h0100, '0, 98, 1'b0, "load 0100");
    chk("load 0100 low word", 32'(bus.rsp_rdata[15:0]), 32'hA000);
    chk("load 0100 high word", 32'(bus.rsp_rdata[1535:1520]), 32'hA05F);

    // Vector table: wrap boundaries and a random store/load pair.
    for (int i = 0; i < 7; i++) begin
      d = rand_bmp();
      run_req(vt[i].we, vt[i].base, d, vt[i].lat, vt[i].err, $sformatf("vec%0d", i));
    end

    // req_valid held high through a store followed by a load.
    d = rand_bmp(); base = 16'h0800;
    first_rdy = 0; rsp1 = 0; rsp2 = 0; rdy_cnt = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = base; bus.req_wdata = d;
    @(negedge clk);
    chk("b2b first ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1; bus.req_we = 1'b0;
    for (int k = 1; k <= 250; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin rdy_cnt++; if (first_rdy == 0) first_rdy = k; end
      if (bus.rsp_valid) begin if (rsp1 == 0) rsp1 = k; else if (rsp2 == 0) rsp2 = k; end
      if (rsp2 != 0) break;
      if (bus.req_ready) begin @(posedge clk); #1; bus.req_valid = 1'b0; end
    end
    bus.req_valid = 1'b0;
    chk("b2b store rsp cycle", 32'(rsp1), 32'd97);
    chk("b2b second accept cycle", 32'(first_rdy), 32'd98);
    chk("b2b load rsp cycle", 32'(rsp2), 32'd196);
    chk("b2b ready count", 32'(rdy_cnt), 32'd1);
    chk_bmp("b2b rdata", bus.rsp_rdata, d);
    ref_store(base, d, int'(BEATS));
    exp_rdata = d;
    @(posedge clk); #1;

    // Random store/load pairs at random bases, some near the top of memory.
    for (int r = 0; r < 5; r++) begin
      d = rand_bmp();
      base = ($urandom_range(0, 2) == 0) ? 16'(16'hFF80 + 16'($urandom_range(0, 127))) : 16'($urandom);
      g = guard_hit(base);
      run_req(1'b1, base, d, g ? 1 : 97, g, $sformatf("rnd%0d store", r));
      run_req(1'b0, base, '0, g ? 1 : 98, g, $sformatf("rnd%0d load", r));
      if (!g) chk_bmp($sformatf("rnd%0d roundtrip", r), bus.rsp_rdata, d);
    end

    // Reset asserted in cycle 40 of a store: beats 0..38 reach memory.
    d = rand_bmp(); base = 16'h0300;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = base; bus.req_wdata = d;
    @(negedge clk);
    chk("abort accept ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1; bus.req_valid = 1'b0;
    repeat (39) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk("abort mem_wren", 32'(mem_wren), 32'd0);
    chk("abort req_ready", 32'(bus.req_ready), 32'd1);
    chk("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk_bmp("abort rsp_rdata", bus.rsp_rdata, '0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    n_rsp = 0; n_wr = 0;
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) n_rsp++;
      if (mem_wren) n_wr++;
    end
    chk("abort no rsp_valid", 32'(n_rsp), 32'd0);
    chk("abort no writes", 32'(n_wr), 32'd0);
    ref_store(base, d, 39);
    exp_rdata = '0;
    @(posedge clk); #1;
    run_req(1'b0, base, '0, 98, 1'b0, "load after abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
